// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: drains the pipeline, strobes the CSR file and redirects fetch.
// Optional nesting (depth 2 with mepc shadow restore) is enabled by defining TRAP_NEST_EN.
module trap_ctrl #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            freeze,
    input  logic            irq_timer,
    input  logic            mtie,
    input  logic            exc_addr,
    input  logic            exc_ecall,
    input  logic            mret_ex,
    input  logic [XLEN-1:0] pc_id_ex,
    input  logic [XLEN-1:0] csr_mtvec,
    input  logic [XLEN-1:0] csr_mepc,
    output logic            trap_en,
    output logic [XLEN-1:0] trap_mepc,
    output logic            addr_exception,
    output logic            mret,
    output logic            mepc_res,
    output logic            flush,
    output logic            pc_redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            in_trap,
    output logic [1:0]      trap_depth,
    output logic            double_fault
);

    typedef enum logic [2:0] {IDLE, DRAIN, SAVE, VECTOR, HANDLER, RET} state_t;

`ifdef TRAP_NEST_EN
    localparam bit NEST = 1'b1;
`else
    localparam bit NEST = 1'b0;
`endif

    state_t          state, state_nxt;
    logic [2:0]      cnt, cnt_nxt;
    logic            cause_addr, cause_addr_nxt;
    logic [XLEN-1:0] mepc_q, mepc_nxt;
    logic [1:0]      depth, depth_nxt;
    logic            dfault, dfault_nxt;
    logic            exc, tmr, pulse_ok, ret_deep;

    assign exc = exc_addr | exc_ecall;
    assign tmr = irq_timer & mtie;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            cause_addr <= 1'b0;
            mepc_q     <= '0;
            depth      <= '0;
            dfault     <= 1'b0;
        end else if (!freeze) begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            cause_addr <= cause_addr_nxt;
            mepc_q     <= mepc_nxt;
            depth      <= depth_nxt;
            dfault     <= dfault_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        cause_addr_nxt = cause_addr;
        mepc_nxt       = mepc_q;
        depth_nxt      = depth;
        dfault_nxt     = dfault;
        case (state)
            IDLE: begin
                if (exc || tmr) begin
                    state_nxt      = DRAIN;
                    cnt_nxt        = 3'(FLUSH_CYCLES - 1);
                    cause_addr_nxt = exc_addr;
                    mepc_nxt       = pc_id_ex;
                end
            end
            DRAIN: begin
                if (cnt == 3'd0) state_nxt = SAVE;
                else             cnt_nxt   = cnt - 3'd1;
            end
            SAVE:   state_nxt = VECTOR;
            VECTOR: begin
                state_nxt = HANDLER;
                depth_nxt = depth + 2'd1;
            end
            HANDLER: begin
                // An exception outranks a simultaneous MRET; timers are masked here.
                if (exc) begin
                    if (NEST && depth == 2'd1) begin
                        state_nxt      = DRAIN;
                        cnt_nxt        = 3'(FLUSH_CYCLES - 1);
                        cause_addr_nxt = exc_addr;
                        mepc_nxt       = pc_id_ex;
                    end else begin
                        dfault_nxt = 1'b1;
                    end
                end else if (mret_ex) begin
                    state_nxt = RET;
                end
            end
            RET: begin
                depth_nxt = depth - 2'd1;
                state_nxt = (depth == 2'd1) ? IDLE : HANDLER;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pulses are suppressed while stalled or while a reset is being applied.
    assign pulse_ok = !freeze && !rst;
    assign ret_deep = (state == RET) && (depth == 2'd2);

    always_comb begin
        flush          = (state == DRAIN) || (state == RET);
        trap_en        = pulse_ok && (state == SAVE);
        addr_exception = pulse_ok && (state == SAVE) && cause_addr;
        mret           = pulse_ok && (state == RET);
        pc_redirect    = pulse_ok && ((state == VECTOR) || (state == RET));
        redirect_pc    = '0;
        if (state == VECTOR)   redirect_pc = csr_mtvec;
        else if (state == RET) redirect_pc = csr_mepc;
    end

`ifdef TRAP_NEST_EN
    assign mepc_res = pulse_ok && ret_deep;
`else
    assign mepc_res = 1'b0 & ret_deep;
`endif

    assign trap_mepc    = mepc_q;
    assign trap_depth   = depth;
    assign in_trap      = (depth != 2'd0);
    assign double_fault = dfault;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboarded random/directed bench for trap_ctrl against a sequence-position reference model.
module tb_trap_ctrl;
    localparam int XLEN = 32;
    localparam int F    = 2;
`ifdef TRAP_NEST_EN
    localparam bit NEST = 1'b1;
`else
    localparam bit NEST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, freeze, irq_timer, mtie, exc_addr, exc_ecall, mret_ex;
    logic [XLEN-1:0] pc_id_ex, csr_mtvec, csr_mepc;
    logic trap_en, addr_exception, mret, mepc_res, flush, pc_redirect, in_trap, double_fault;
    logic [XLEN-1:0] trap_mepc, redirect_pc;
    logic [1:0] trap_depth;

    always #5 clk = ~clk;

    trap_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(F)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .irq_timer(irq_timer), .mtie(mtie),
        .exc_addr(exc_addr), .exc_ecall(exc_ecall), .mret_ex(mret_ex),
        .pc_id_ex(pc_id_ex), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
        .trap_en(trap_en), .trap_mepc(trap_mepc), .addr_exception(addr_exception),
        .mret(mret), .mepc_res(mepc_res), .flush(flush), .pc_redirect(pc_redirect),
        .redirect_pc(redirect_pc), .in_trap(in_trap), .trap_depth(trap_depth),
        .double_fault(double_fault)
    );

    typedef struct {
        logic flush, trap_en, addr_exc, mret, mepc_res, pc_redirect, in_trap, dfault;
        logic [XLEN-1:0] trap_mepc, redirect_pc;
        logic [1:0] depth;
    } exp_t;

    exp_t exp_q[$];
    int n_vec = 0;
    int n_bad = 0;

    // Reference model: pos counts active cycles since a trap was accepted
    // (1..F flush, F+1 save, F+2 vector); ret marks the one-cycle return.
    int pos = 0;
    int depth = 0;
    bit ret = 0, cause_a = 0, dfault = 0;
    logic [XLEN-1:0] mepc_lat = '0;

    task automatic cyc(input bit r, input bit f, input bit irq, input bit tie, input bit ea,
                       input bit ec, input bit mr, input logic [XLEN-1:0] pc,
                       input logic [XLEN-1:0] tv, input logic [XLEN-1:0] ep);
        exp_t e;
        bit ok, exc;
        @(posedge clk);
        #1;
        rst = r; freeze = f; irq_timer = irq; mtie = tie; exc_addr = ea; exc_ecall = ec;
        mret_ex = mr; pc_id_ex = pc; csr_mtvec = tv; csr_mepc = ep;
        ok            = !f && !r;
        e.flush       = (pos >= 1 && pos <= F) || ret;
        e.trap_en     = ok && pos == F + 1;
        e.addr_exc    = ok && pos == F + 1 && cause_a;
        e.mret        = ok && ret;
        e.mepc_res    = ok && ret && depth == 2;
        e.pc_redirect = ok && (pos == F + 2 || ret);
        e.redirect_pc = (pos == F + 2) ? tv : (ret ? ep : '0);
        e.in_trap     = depth != 0;
        e.dfault      = dfault;
        e.trap_mepc   = mepc_lat;
        e.depth       = 2'(depth);
        exp_q.push_back(e);
        exc = ea || ec;
        if (r) begin
            pos = 0; depth = 0; ret = 0; cause_a = 0; dfault = 0; mepc_lat = '0;
        end else if (!f) begin
            if (ret) begin
                depth--; ret = 0;
            end else if (pos > 0) begin
                if (pos == F + 2) begin pos = 0; depth++; end
                else pos++;
            end else if (depth == 0) begin
                if (exc || (irq && tie)) begin pos = 1; cause_a = ea; mepc_lat = pc; end
            end else if (exc) begin
                if (NEST && depth == 1) begin pos = 1; cause_a = ea; mepc_lat = pc; end
                else dfault = 1;
            end else if (mr) begin
                ret = 1;
            end
        end
    endtask

    task automatic idle(input int n, input logic [XLEN-1:0] tv, input logic [XLEN-1:0] ep);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 32'h0, tv, ep);
    endtask

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        if (act !== req) begin
            n_bad++;
            $display("FAIL vec%0d %s: got %0h want %0h", n_vec, name, act, req);
        end
    endtask

    // Monitor: the DUT presents a response every cycle; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                chk("flush", 32'(flush), 32'(e.flush));
                chk("trap_en", 32'(trap_en), 32'(e.trap_en));
                chk("addr_exception", 32'(addr_exception), 32'(e.addr_exc));
                chk("mret", 32'(mret), 32'(e.mret));
                chk("mepc_res", 32'(mepc_res), 32'(e.mepc_res));
                chk("pc_redirect", 32'(pc_redirect), 32'(e.pc_redirect));
                chk("redirect_pc", redirect_pc, e.redirect_pc);
                chk("in_trap", 32'(in_trap), 32'(e.in_trap));
                chk("double_fault", 32'(double_fault), 32'(e.dfault));
                chk("trap_mepc", trap_mepc, e.trap_mepc);
                chk("trap_depth", 32'(trap_depth), 32'(e.depth));
            end
        end
    end

    initial begin
        rst = 1; freeze = 0; irq_timer = 0; mtie = 0; exc_addr = 0; exc_ecall = 0; mret_ex = 0;
        pc_id_ex = '0; csr_mtvec = '0; csr_mepc = '0;
        cyc(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        cyc(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        idle(2, 32'h80, 32'h104);
        // Misaligned address at 0x100, vector 0x80, then return to 0x104.
        cyc(0, 0, 0, 0, 1, 0, 0, 32'h100, 32'h80, 32'h104);
        idle(6, 32'h80, 32'h104);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h80, 32'h104);
        idle(2, 32'h80, 32'h104);
        // Timer masked, then enabled, then held high in the handler.
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 0, 0, 32'h300, 32'h80, 32'h104);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 1, 0, 0, 0, 32'h300, 32'h80, 32'h104);
        cyc(0, 0, 0, 1, 0, 0, 1, 32'h0, 32'h80, 32'h304);
        idle(2, 32'h80, 32'h104);
        // ECALL, then a second ECALL from inside the handler.
        cyc(0, 0, 0, 0, 0, 1, 0, 32'h200, 32'h80, 32'h204);
        idle(6, 32'h80, 32'h204);
        cyc(0, 0, 0, 0, 0, 1, 0, 32'h90, 32'h80, 32'h204);
        idle(6, 32'h80, 32'h94);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h80, 32'h94);
        idle(2, 32'h80, 32'h204);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h80, 32'h204);
        idle(2, 32'h80, 32'h204);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h80, 32'h204);
        idle(2, 32'h80, 32'h204);
        // Freeze inside DRAIN, then exception and MRET together in the handler.
        cyc(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h80, 32'h0);
        cyc(0, 0, 0, 0, 1, 0, 0, 32'h400, 32'h80, 32'h0);
        idle(1, 32'h80, 32'h0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0, 0, 32'h0, 32'h80, 32'h0);
        idle(5, 32'h80, 32'h0);
        cyc(0, 0, 0, 0, 1, 0, 1, 32'h500, 32'h80, 32'h404);
        idle(6, 32'h80, 32'h404);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h80, 32'h404);
        idle(2, 32'h80, 32'h404);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h80, 32'h404);
        idle(2, 32'h80, 32'h404);
        // Reset while in SAVE.
        cyc(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h80, 32'h0);
        cyc(0, 0, 0, 0, 0, 1, 0, 32'h600, 32'h80, 32'h0);
        idle(2, 32'h80, 32'h0);
        cyc(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h80, 32'h0);
        idle(3, 32'h80, 32'h0);
        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 9) == 0), $urandom_range(0, 1) == 1,
                ($urandom_range(0, 24) == 0), ($urandom_range(0, 24) == 0),
                ($urandom_range(0, 5) == 0),
                {$urandom_range(0, 32'h3fff_ffff), 2'b00},
                {$urandom_range(0, 32'h3fff_ffff), 2'b00},
                {$urandom_range(0, 32'h3fff_ffff), 2'b00});
        end
        @(posedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d responses left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
